lemming_array_ctrl: RTL and testbench

- Parametrised bank of NUM_CH independent lemming walker FSMs sharing one clock and reset.
- Each channel adds directional falling, splatter after an over-long fall, and a revive input.
- Provides an aggregate count of live channels.
- Used wherever several walkers are simulated in parallel.

---
 rtl/lemming_array_ctrl.sv | 110 +++++++++++
 tb/tb_lemming_array_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lemming_array_ctrl.sv
// Bank of independent lemming walker FSMs. Each channel walks, digs, falls,
// splats after an over-long fall and can be revived; alive_count reports
// how many channels are not dead.
module lemming_array_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int SPLAT_LIMIT = 20,
  parameter int CNT_W       = $clog2(SPLAT_LIMIT + 2),
  parameter int ALIVE_W     = $clog2(NUM_CH + 1)
) (
  input  logic               clk,
  input  logic               areset,
  input  logic [NUM_CH-1:0]  bump_left,
  input  logic [NUM_CH-1:0]  bump_right,
  input  logic [NUM_CH-1:0]  ground,
  input  logic [NUM_CH-1:0]  dig,
  input  logic [NUM_CH-1:0]  revive,
  output logic [NUM_CH-1:0]  walk_left,
  output logic [NUM_CH-1:0]  walk_right,
  output logic [NUM_CH-1:0]  aaah,
  output logic [NUM_CH-1:0]  digging,
  output logic [NUM_CH-1:0]  splat,
  output logic [ALIVE_W-1:0] alive_count
);

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SPLAT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(SPLAT_LIMIT + 1);

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];

  // State and fall-counter registers; reset aborts any fall or dig.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= WALK_L;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-channel next state and fall counter. cnt_q+1 is the number of
  // aaah cycles so far, so landing is fatal once cnt_q reaches the limit.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      unique case (state_q[i])
        WALK_L: begin
          if (!ground[i])       state_d[i] = FALL_L;
          else if (dig[i])      state_d[i] = DIG_L;
          else if (bump_left[i]) state_d[i] = WALK_R;
        end
        WALK_R: begin
          if (!ground[i])        state_d[i] = FALL_R;
          else if (dig[i])       state_d[i] = DIG_R;
          else if (bump_right[i]) state_d[i] = WALK_L;
        end
        DIG_L: if (!ground[i]) state_d[i] = FALL_L;
        DIG_R: if (!ground[i]) state_d[i] = FALL_R;
        FALL_L, FALL_R: begin
          if (!ground[i]) begin
            cnt_d[i] = (cnt_q[i] == CNT_SAT) ? cnt_q[i] : cnt_q[i] + 1'b1;
          end else if (cnt_q[i] >= CNT_LIMIT) begin
            state_d[i] = SPLAT;
          end else begin
            state_d[i] = (state_q[i] == FALL_L) ? WALK_L : WALK_R;
          end
        end
        SPLAT: if (revive[i]) state_d[i] = WALK_L;
        default: state_d[i] = WALK_L;
      endcase
    end
  end

  // Moore output decode and live-channel popcount from registered state.
  always_comb begin
    walk_left   = '0;
    walk_right  = '0;
    aaah        = '0;
    digging     = '0;
    splat       = '0;
    alive_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      walk_left[i]  = (state_q[i] == WALK_L) || (state_q[i] == DIG_L);
      walk_right[i] = (state_q[i] == WALK_R) || (state_q[i] == DIG_R);
      aaah[i]       = (state_q[i] == FALL_L) || (state_q[i] == FALL_R);
      digging[i]    = (state_q[i] == DIG_L)  || (state_q[i] == DIG_R);
      splat[i]      = (state_q[i] == SPLAT);
      if (state_q[i] != SPLAT) alive_count = alive_count + ALIVE_W'(1);
    end
  end

endmodule

// File: tb/tb_lemming_array_ctrl.sv
// Directed bench for lemming_array_ctrl with hand-computed expectations.
module tb_lemming_array_ctrl;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic [3:0] bump_left = '0, bump_right = '0, ground = 4'hF, dig = '0, revive = '0;
  logic [3:0] walk_left, walk_right, aaah, digging, splat;
  logic [2:0] alive_count;

  int n_tests = 0;
  int n_fail  = 0;

  lemming_array_ctrl #(.NUM_CH(4), .SPLAT_LIMIT(20)) dut (
    .clk(clk), .areset(areset),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground),
    .dig(dig), .revive(revive),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .digging(digging), .splat(splat), .alive_count(alive_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, land 1ns after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset between edges, no clock needed for outputs
    #1 areset = 1'b1;
    #1;
    chk("rst_walk_left", walk_left, 4'hF);
    chk("rst_walk_right", walk_right, 4'h0);
    chk("rst_aaah", aaah, 4'h0);
    chk("rst_digging", digging, 4'h0);
    chk("rst_splat", splat, 4'h0);
    chk("rst_alive", alive_count, 3'd4);
    #1 areset = 1'b0;
    step(1);
    chk("idle_walk_left", walk_left, 4'hF);

    // ch0: bump turns right, both bumps turn back left
    bump_left = 4'b0001;
    step(1);
    chk("ch0_turn_r", walk_right, 4'b0001);
    chk("ch0_turn_r_wl", walk_left, 4'b1110);
    bump_left = 4'b0001; bump_right = 4'b0001;
    step(1);
    chk("ch0_both_bumps", walk_left, 4'hF);
    bump_left = '0; bump_right = '0;

    // ch1: bump into WALK_R, then fall beats dig and bump
    bump_left = 4'b0010;
    step(1);
    chk("ch1_walk_r", walk_right, 4'b0010);
    bump_left = '0;
    // a bump on the non-walking side is ignored
    bump_left = 4'b0010;
    step(1);
    chk("ch1_ignore_bl", walk_right, 4'b0010);
    bump_left = '0;
    ground = 4'b1101; dig = 4'b0010; bump_right = 4'b0010;
    step(1);
    chk("ch1_fall", aaah, 4'b0010);
    chk("ch1_fall_nodig", digging, 4'b0000);
    step(2);
    chk("ch1_fall3", aaah, 4'b0010);
    ground = 4'hF;
    step(1);
    chk("ch1_land_wr", walk_right, 4'b0010);
    chk("ch1_land_nodig", digging, 4'b0000);
    chk("ch1_land_aaah", aaah, 4'b0000);
    dig = '0; bump_right = '0;

    // ch2: dig, bumps ignored, fall through, land left
    dig = 4'b0100;
    step(1);
    chk("ch2_dig", digging, 4'b0100);
    chk("ch2_dig_wl", walk_left, 4'b1101);
    dig = '0; bump_left = 4'b0100; bump_right = 4'b0100;
    step(1);
    chk("ch2_dig_bump", digging, 4'b0100);
    chk("ch2_dig_bump_wl", walk_left, 4'b1101);
    bump_left = '0; bump_right = '0;
    ground = 4'b1011;
    step(1);
    chk("ch2_fall", aaah, 4'b0100);
    chk("ch2_fall_nodig", digging, 4'b0000);
    ground = 4'hF;
    step(1);
    chk("ch2_land_wl", walk_left, 4'b1101);
    chk("ch2_land_nodig", digging, 4'b0000);

    // ch3: 20 aaah cycles survive
    ground = 4'b0111;
    step(20);
    chk("ch3_fall20", aaah, 4'b1000);
    ground = 4'hF;
    step(1);
    chk("ch3_survive20", walk_left, 4'b1101);
    chk("ch3_survive20_splat", splat, 4'b0000);

    // ch3: 21 aaah cycles is fatal
    ground = 4'b0111;
    step(21);
    chk("ch3_fall21", aaah, 4'b1000);
    ground = 4'hF;
    step(1);
    chk("ch3_splat", splat, 4'b1000);
    chk("ch3_splat_wl", walk_left, 4'b0101);
    chk("ch3_splat_aaah", aaah, 4'b0000);
    chk("ch3_alive3", alive_count, 3'd3);

    // dead channel ignores everything except revive
    for (int i = 0; i < 50; i++) begin
      bump_left  = {i[0], 3'b000};
      bump_right = {i[1], 3'b000};
      dig        = {i[2], 3'b000};
      ground     = {i[3], 3'b111};
      step(1);
    end
    chk("ch3_dead50", splat, 4'b1000);
    chk("ch3_dead50_out", walk_left[3] | walk_right[3] | aaah[3] | digging[3], 1'b0);
    bump_left = '0; bump_right = '0; dig = '0; ground = 4'hF;

    // revive
    revive = 4'b1000;
    step(1);
    revive = '0;
    chk("ch3_revive_wl", walk_left, 4'b1101);
    chk("ch3_revive_splat", splat, 4'b0000);
    chk("ch3_revive_alive", alive_count, 3'd4);
    revive = 4'b0010;
    step(1);
    revive = '0;
    chk("ch1_revive_live", walk_right, 4'b0010);
    chk("ch1_revive_live_wl", walk_left, 4'b1101);

    // areset mid-fall clears the counter
    ground = 4'b0111;
    step(15);
    chk("ch3_prefall", aaah, 4'b1000);
    #1 areset = 1'b1;
    #1;
    chk("rst_midfall_aaah", aaah, 4'b0000);
    chk("rst_midfall_wl", walk_left, 4'hF);
    #1 areset = 1'b0;
    step(20);
    chk("ch3_refall20", aaah, 4'b1000);
    ground = 4'hF;
    step(1);
    chk("ch3_post_rst_survive", walk_left, 4'hF);
    chk("ch3_post_rst_splat", splat, 4'b0000);

    // very long fall: counter saturates, still fatal
    ground = 4'b0111;
    step(40);
    chk("ch3_fall40", aaah, 4'b1000);
    ground = 4'hF;
    step(1);
    chk("ch3_long_splat", splat, 4'b1000);
    chk("ch3_long_alive", alive_count, 3'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
